uart_wb_master: RTL and testbench
=================================

UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 SHALL have parameter dw, default 32, data width of the command and bus data paths.
REQ-002 SHALL have parameter aw, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, the maximum number of bus cycles to wait for wb_ack_i/wb_err_i (range 1..255).
REQ-004 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, the read data returned on an aborted read.
REQ-005 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-006 clk  input  1  clock; all state changes on the rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 cpu_address  input  aw  transaction byte address from the packet decoder.
REQ-009 cpu_start  input  1  request, held high by the decoder until it sees cpu_active.
REQ-010 cpu_selection  input  4  byte-lane select.
REQ-011 cpu_write  input  1  1 = write, 0 = read.
REQ-012 cpu_data_wr  input  dw  write data.
REQ-013 cpu_data_rd  output  dw  read data, valid once cpu_active falls.
REQ-014 cpu_active  output  1  transaction in progress.
REQ-015 bus_error  output  1  last transaction aborted by error or timeout (sticky).
REQ-016 wb_adr_o  output  aw; wb_dat_o  output  dw; wb_sel_o  output  4; wb_we_o  output  1; wb_cyc_o  output  1; wb_stb_o  output  1.
REQ-017 wb_dat_i  input  dw; wb_ack_i  input  1; wb_err_i  input  1 (Wishbone classic slave response).

Function
REQ-018 SHALL implement the states IDLE, BUS and DONE.
REQ-019 SHALL register cpu_start every cycle as start_q, and SHALL accept a request only in IDLE when cpu_start=1 and start_q=0 (rising edge); a cpu_start held high after completion SHALL NOT start a second transaction.
REQ-020 On acceptance (edge N), the block SHALL latch cpu_address, cpu_data_wr, cpu_selection and cpu_write into wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o, set wb_cyc_o=wb_stb_o=1 and cpu_active=1, clear bus_error and the timeout counter, and go to BUS, all visible at cycle N+1.
REQ-021 In BUS, wb_adr_o, wb_dat_o, wb_sel_o and wb_we_o SHALL stay constant, and input changes SHALL be ignored.
REQ-022 In BUS, when wb_ack_i=1 and wb_err_i=0 at edge M, the block SHALL clear wb_cyc_o, wb_stb_o and wb_we_o, capture wb_dat_i into cpu_data_rd (reads only), and go to DONE; cpu_active SHALL remain 1.
REQ-023 In BUS, wb_err_i=1 at edge M (err wins over a simultaneous ack) SHALL behave as an ack, except that cpu_data_rd SHALL be ERR_DATA on reads and bus_error SHALL be set to 1.
REQ-024 In BUS, the timeout counter SHALL increment each cycle with no response; when TIMEOUT cycles have elapsed without ack or err, the block SHALL abort exactly as in REQ-023.
REQ-025 A response arriving on the same edge as the timeout SHALL take precedence over the timeout.
REQ-026 In DONE, the block SHALL clear cpu_active and return to IDLE at the next edge, so cpu_active is high for at least two cycles per transaction.
REQ-027 cpu_data_rd SHALL hold its value until the next completed read, and SHALL be unchanged by writes.
REQ-028 bus_error SHALL hold its value until the next accepted request.
REQ-029 Write-to-read turnaround: the minimum spacing between accepted requests SHALL be 3 cycles (accept, BUS, DONE).
REQ-030 The timeout counter SHALL be 8 bits wide and SHALL saturate rather than wrap.

Reset
REQ-031 When rst=1 at an edge, the block SHALL enter IDLE and set every output to 0 (cpu_data_rd=0, bus_error=0, all wb_* outputs=0), clear start_q and the counter, and SHALL do so even in mid-transaction with no Wishbone handshake completed.
REQ-032 After reset release, a cpu_start already high SHALL NOT be accepted until it has been seen low for at least one cycle.

Verification
REQ-033 Write: addr=0x0000_0010, data=0xA5A5_1234, sel=0xF, ack after 2 wait cycles -> wb_we_o=1 and wb_adr_o=0x10 for 3 cycles; cpu_active high for 4 cycles; bus_error=0.
REQ-034 Read: addr=0x20, slave returns 0xCAFE_F00D with zero-wait ack -> cpu_data_rd=0xCAFE_F00D when cpu_active falls, held after cpu_start is removed.
REQ-035 cpu_start held high for 10 cycles -> exactly one Wishbone cycle is issued.
REQ-036 Read with no slave response, TIMEOUT=4 -> stb drops after 4 cycles, cpu_data_rd=0xDEAD_BEEF, bus_error=1, and the next accepted request clears bus_error.
REQ-037 wb_ack_i and wb_err_i asserted together on a read -> cpu_data_rd=ERR_DATA and bus_error=1.
REQ-038 rst asserted while in BUS -> next cycle all outputs=0; a new request after reset completes normally.

Source files
------------

// File: rtl/uart_wb_master.sv
// uart_wb_master: turns single-word requests from the UART packet decoder
// into Wishbone classic bus cycles, with a response timeout and a sticky
// bus_error flag for aborted transactions.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for a rising edge on cpu_start
//   S_BUS  | Wishbone cycle open, waiting for ack/err or timeout
//   S_DONE | bus released, cpu_active drops at the next edge
module uart_wb_master #(
    parameter int            dw       = 32,
    parameter int            aw       = 32,
    parameter int            TIMEOUT  = 255,
    parameter logic [dw-1:0] ERR_DATA = dw'(32'hDEAD_BEEF)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [aw-1:0] cpu_address,
    input  logic          cpu_start,
    input  logic [3:0]    cpu_selection,
    input  logic          cpu_write,
    input  logic [dw-1:0] cpu_data_wr,
    output logic [dw-1:0] cpu_data_rd,
    output logic          cpu_active,
    output logic          bus_error,
    output logic [aw-1:0] wb_adr_o,
    output logic [dw-1:0] wb_dat_o,
    output logic [3:0]    wb_sel_o,
    output logic          wb_we_o,
    output logic          wb_cyc_o,
    output logic          wb_stb_o,
    input  logic [dw-1:0] wb_dat_i,
    input  logic          wb_ack_i,
    input  logic          wb_err_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // The counter starts at 0 on acceptance, so the abort fires on the
    // edge that closes the TIMEOUT-th bus cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_start_q;
    logic       r_armed;
    logic [7:0] r_cnt;

    logic       w_accept;
    logic       w_in_bus;
    logic       w_timeout;
    logic       w_finish;
    logic       w_abort;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_BUS;
            S_BUS:   if (w_finish) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Control strobes: acceptance, completion and abort decisions.
    // r_armed blocks a cpu_start that was already high through reset.
    always_comb begin
        w_accept  = (r_state == S_IDLE) && cpu_start && !r_start_q && r_armed;
        w_in_bus  = (r_state == S_BUS);
        w_timeout = (r_cnt >= TO_LAST);
        w_finish  = w_in_bus && (wb_ack_i || wb_err_i || w_timeout);
        w_abort   = w_in_bus && (wb_err_i || (!wb_ack_i && w_timeout));
    end

    // Registered outputs, start edge detector and timeout counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q   <= 1'b0;
            r_armed     <= 1'b0;
            r_cnt       <= 8'd0;
            cpu_data_rd <= '0;
            cpu_active  <= 1'b0;
            bus_error   <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= 4'd0;
            wb_we_o     <= 1'b0;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
        end else begin
            r_start_q <= cpu_start;
            if (!cpu_start) begin
                r_armed <= 1'b1;
            end

            if (w_accept) begin
                wb_adr_o   <= cpu_address;
                wb_dat_o   <= cpu_data_wr;
                wb_sel_o   <= cpu_selection;
                wb_we_o    <= cpu_write;
                wb_cyc_o   <= 1'b1;
                wb_stb_o   <= 1'b1;
                cpu_active <= 1'b1;
                bus_error  <= 1'b0;
                r_cnt      <= 8'd0;
            end else if (w_finish) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                wb_we_o  <= 1'b0;
                if (!wb_we_o) begin
                    cpu_data_rd <= w_abort ? ERR_DATA : wb_dat_i;
                end
                if (w_abort) begin
                    bus_error <= 1'b1;
                end
            end else if (w_in_bus) begin
                if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end else if (r_state == S_DONE) begin
                cpu_active <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_wb_master.sv
// Directed bench for uart_wb_master with TIMEOUT=4 and a scripted
// Wishbone slave that answers after a chosen number of wait cycles.
module tb_uart_wb_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_address;
    logic        cpu_start;
    logic [3:0]  cpu_selection;
    logic        cpu_write;
    logic [31:0] cpu_data_wr;
    logic [31:0] cpu_data_rd;
    logic        cpu_active;
    logic        bus_error;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i;
    logic        wb_err_i;

    always #5 clk = ~clk;

    uart_wb_master #(
        .dw(32), .aw(32), .TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_address(cpu_address), .cpu_start(cpu_start),
        .cpu_selection(cpu_selection), .cpu_write(cpu_write),
        .cpu_data_wr(cpu_data_wr), .cpu_data_rd(cpu_data_rd),
        .cpu_active(cpu_active), .bus_error(bus_error),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rd"},    cpu_data_rd, 32'h0);
        chk({tag, "_act"},   {31'd0, cpu_active}, 32'h0);
        chk({tag, "_berr"},  {31'd0, bus_error}, 32'h0);
        chk({tag, "_adr"},   wb_adr_o, 32'h0);
        chk({tag, "_dat"},   wb_dat_o, 32'h0);
        chk({tag, "_ctl"},   {24'd0, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, 1'b0}, 32'h0);
    endtask

    // mode: 0 = ack, 1 = err, 2 = ack+err together, 3 = no response.
    // The slave responds once stb has been seen for waits+1 cycles.
    task automatic run_txn(
        input  logic        w,
        input  logic [31:0] a,
        input  logic [31:0] d,
        input  logic [3:0]  s,
        input  int          waits,
        input  int          mode,
        input  logic [31:0] rdata,
        output int          n_stb,
        output int          n_we,
        output int          n_act,
        output int          n_starts,
        output logic [31:0] rd_fall,
        output logic        err_fall,
        output logic        err_first
    );
        logic prev_stb;
        logic prev_act;
        prev_stb  = 1'b0;
        prev_act  = 1'b0;
        n_stb     = 0;
        n_we      = 0;
        n_act     = 0;
        n_starts  = 0;
        rd_fall   = 32'hxxxx_xxxx;
        err_fall  = 1'bx;
        err_first = 1'bx;
        cpu_address   = a;
        cpu_data_wr   = d;
        cpu_selection = s;
        cpu_write     = w;
        wb_dat_i      = rdata;
        cpu_start     = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (cpu_active && n_act == 0) err_first = bus_error;
            if (cpu_active) begin
                n_act++;
                cpu_start     = 1'b0;
                cpu_address   = ~a;
                cpu_data_wr   = ~d;
                cpu_selection = ~s;
                cpu_write     = ~w;
            end
            if (wb_stb_o) begin
                n_stb++;
                if (!prev_stb) n_starts++;
                if (wb_we_o) n_we++;
                chk("adr_hold", wb_adr_o, a);
                chk("dat_hold", wb_dat_o, d);
                chk("sel_we_hold", {27'd0, wb_sel_o, wb_we_o}, {27'd0, s, w});
            end
            if (prev_act && !cpu_active) begin
                rd_fall  = cpu_data_rd;
                err_fall = bus_error;
            end
            prev_stb = wb_stb_o;
            prev_act = cpu_active;
            wb_ack_i = 1'b0;
            wb_err_i = 1'b0;
            if (wb_stb_o && mode != 3 && n_stb == waits + 1) begin
                if (mode == 0 || mode == 2) wb_ack_i = 1'b1;
                if (mode == 1 || mode == 2) wb_err_i = 1'b1;
            end
        end
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
    endtask

    int          n_stb, n_we, n_act, n_starts;
    logic [31:0] rd_fall;
    logic        err_fall, err_first;
    int          rises;
    logic        prev;

    initial begin
        rst = 1'b1;
        cpu_address = 32'h0; cpu_start = 1'b0; cpu_selection = 4'h0;
        cpu_write = 1'b0; cpu_data_wr = 32'h0;
        wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // write, 2 wait cycles
        run_txn(1'b1, 32'h10, 32'hA5A5_1234, 4'hF, 2, 0, 32'h0,
                n_stb, n_we, n_act, n_starts, rd_fall, err_fall, err_first);
        chk("wr_stb_cycles", n_stb, 3);
        chk("wr_we_cycles", n_we, 3);
        chk("wr_act_cycles", n_act, 4);
        chk("wr_berr", {31'd0, err_fall}, 32'd0);

        // read, zero wait
        run_txn(1'b0, 32'h20, 32'h0, 4'hF, 0, 0, 32'hCAFE_F00D,
                n_stb, n_we, n_act, n_starts, rd_fall, err_fall, err_first);
        chk("rd_stb_cycles", n_stb, 1);
        chk("rd_act_cycles", n_act, 2);
        chk("rd_data_fall", rd_fall, 32'hCAFE_F00D);
        chk("rd_data_hold", cpu_data_rd, 32'hCAFE_F00D);

        // write terminated by err: read data untouched, error flagged
        run_txn(1'b1, 32'h30, 32'h5555_AAAA, 4'h3, 0, 1, 32'h0,
                n_stb, n_we, n_act, n_starts, rd_fall, err_fall, err_first);
        chk("wrerr_berr", {31'd0, err_fall}, 32'd1);
        chk("wrerr_rd_kept", rd_fall, 32'hCAFE_F00D);

        // read, no response: timeout after 4 cycles
        run_txn(1'b0, 32'h24, 32'h0, 4'hC, 0, 3, 32'h1357_9BDF,
                n_stb, n_we, n_act, n_starts, rd_fall, err_fall, err_first);
        chk("to_berr_clr_on_accept", {31'd0, err_first}, 32'd0);
        chk("to_stb_cycles", n_stb, 4);
        chk("to_act_cycles", n_act, 5);
        chk("to_rd_data", rd_fall, 32'hDEAD_BEEF);
        chk("to_berr", {31'd0, err_fall}, 32'd1);
        chk("to_berr_sticky", {31'd0, bus_error}, 32'd1);

        // ack on the same edge as the timeout: ack wins
        run_txn(1'b0, 32'h28, 32'h0, 4'hF, 3, 0, 32'h1111_2222,
                n_stb, n_we, n_act, n_starts, rd_fall, err_fall, err_first);
        chk("edge_berr_clr_on_accept", {31'd0, err_first}, 32'd0);
        chk("edge_stb_cycles", n_stb, 4);
        chk("edge_rd_data", rd_fall, 32'h1111_2222);
        chk("edge_berr", {31'd0, err_fall}, 32'd0);

        // ack and err together on a read
        run_txn(1'b0, 32'h2C, 32'h0, 4'hF, 1, 2, 32'h7777_8888,
                n_stb, n_we, n_act, n_starts, rd_fall, err_fall, err_first);
        chk("both_stb_cycles", n_stb, 2);
        chk("both_rd_data", rd_fall, 32'hDEAD_BEEF);
        chk("both_berr", {31'd0, err_fall}, 32'd1);

        // cpu_start held high for 10 cycles: one bus cycle only
        cpu_address = 32'h50; cpu_write = 1'b0; cpu_selection = 4'hF;
        wb_dat_i = 32'h0BAD_F00D;
        cpu_start = 1'b1;
        rises = 0;
        prev = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (wb_cyc_o && !prev) rises++;
            prev = wb_cyc_o;
            wb_ack_i = wb_stb_o;
            if (i == 9) cpu_start = 1'b0;
        end
        wb_ack_i = 1'b0;
        chk("held_start_cycles", rises, 1);
        chk("held_start_rd", cpu_data_rd, 32'h0BAD_F00D);

        // reset in the middle of a bus cycle, start still high through it
        cpu_address = 32'h40; cpu_write = 1'b0; cpu_start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midbus_stb", {31'd0, wb_stb_o}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midbus_rst");
        rst = 1'b0;
        rises = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_cyc_o) rises++;
        end
        chk("post_rst_start_ignored", rises, 0);
        cpu_start = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 32'h44, 32'h0, 4'hF, 0, 0, 32'h1234_5678,
                n_stb, n_we, n_act, n_starts, rd_fall, err_fall, err_first);
        chk("post_rst_starts", n_starts, 1);
        chk("post_rst_rd", rd_fall, 32'h1234_5678);
        chk("post_rst_berr", {31'd0, err_fall}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
